// File: rtl/des_iterative_core_pkg.sv
// Shared DES definitions: FSM states, permutation/S-box tables, key-schedule shifts.
// Tables use DES 1-based bit numbering; DES bit 1 is the MSB of each vector.
package des_iterative_core_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} state_t;

    localparam int unsigned IP_TAB [64] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int unsigned FP_TAB [64] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int unsigned E_TAB [48] = '{
        32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int unsigned P_TAB [32] = '{
        16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int unsigned PC1_TAB [56] = '{
        57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int unsigned PC2_TAB [48] = '{
        14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
        41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

    // Each box is 64 entries, row-major: index = row*16 + col.
    localparam int unsigned SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TAB[i])];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TAB[i])];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int unsigned i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TAB[i])];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int unsigned i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TAB[i])];
        return y;
    endfunction

    function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] b);
        return 4'(SBOX[n][{b[5], b[0], b[4:1]}]);
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] p;
        e = '0;
        for (int unsigned i = 0; i < 48; i++) e[6'(47 - i)] = r[5'(32 - E_TAB[i])];
        e = e ^ k;
        s = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            s = {s[27:0], sbox(3'(i), e[47:42])};
            e = {e[41:0], 6'b0};
        end
        p = '0;
        for (int unsigned i = 0; i < 32; i++) p[5'(31 - i)] = s[5'(32 - P_TAB[i])];
        return p;
    endfunction

    // Decrypt walks the schedule backwards: round 1 reuses C0/D0 since 28 total shifts wrap.
    function automatic logic [1:0] shift_amt(input logic [4:0] rnd, input logic dec);
        logic single;
        single = (rnd == 5'd2) || (rnd == 5'd9) || (rnd == 5'd16);
        if (rnd == 5'd1) return dec ? 2'd0 : 2'd1;
        return single ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/des_iterative_core_round_stage.sv
// One combinational DES round: key-schedule step, subkey, Feistel update.
module des_iterative_core_round_stage
    import des_iterative_core_pkg::*;
#(
    parameter bit ENABLE_DECRYPT = 1'b1
)(
    input  logic [31:0] l_in,
    input  logic [31:0] r_in,
    input  logic [27:0] c_in,
    input  logic [27:0] d_in,
    input  logic [4:0]  round_idx,
    input  logic        mode,
    output logic [31:0] l_out,
    output logic [31:0] r_out,
    output logic [27:0] c_out,
    output logic [27:0] d_out
);
    logic       dec;
    logic [1:0] amt;

    always_comb begin
        dec   = mode & ENABLE_DECRYPT;
        amt   = shift_amt(round_idx, dec);
        c_out = c_in;
        d_out = d_in;
        if (dec) begin
            if (amt == 2'd1) begin
                c_out = {c_in[0], c_in[27:1]};
                d_out = {d_in[0], d_in[27:1]};
            end else if (amt == 2'd2) begin
                c_out = {c_in[1:0], c_in[27:2]};
                d_out = {d_in[1:0], d_in[27:2]};
            end
        end else if (amt == 2'd1) begin
            c_out = {c_in[26:0], c_in[27]};
            d_out = {d_in[26:0], d_in[27]};
        end else begin
            c_out = {c_in[25:0], c_in[27:26]};
            d_out = {d_in[25:0], d_in[27:26]};
        end
        l_out = r_in;
        r_out = l_in ^ feistel(r_in, pc2_perm({c_out, d_out}));
    end

endmodule

// File: rtl/des_iterative_core.sv
// Iterative DES engine: IP, 16 Feistel rounds folded ROUNDS_PER_CYCLE per clock, FP.
// Valid/ready on both sides; a single block in flight.
module des_iterative_core
    import des_iterative_core_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter bit          ENABLE_DECRYPT   = 1'b1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        plaintext_valid_din,
    output logic        plaintext_ready_dout,
    input  logic [63:0] plaintext_din,
    input  logic [63:0] key_din,
    input  logic        decrypt_din,
    output logic        ciphertext_valid_dout,
    input  logic        ciphertext_ready_din,
    output logic [63:0] ciphertext_dout,
    output logic        busy_dout
);
    localparam int unsigned N_CYC = 16 / ROUNDS_PER_CYCLE;
    localparam int unsigned CW    = $clog2(N_CYC) + 1;

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
        $error("des_iterative_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_t        state, state_nxt;
    logic [31:0]   l_q, r_q;
    logic [27:0]   c_q, d_q;
    logic [CW-1:0] round_cnt;
    logic          mode_q;
    logic          last_step;
    logic [4:0]    base_idx;

    logic [31:0] l_ch [ROUNDS_PER_CYCLE+1];
    logic [31:0] r_ch [ROUNDS_PER_CYCLE+1];
    logic [27:0] c_ch [ROUNDS_PER_CYCLE+1];
    logic [27:0] d_ch [ROUNDS_PER_CYCLE+1];

    assign l_ch[0]   = l_q;
    assign r_ch[0]   = r_q;
    assign c_ch[0]   = c_q;
    assign d_ch[0]   = d_q;
    assign base_idx  = 5'(32'(round_cnt) * ROUNDS_PER_CYCLE);
    assign last_step = (round_cnt == CW'(N_CYC - 1));

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_stage
        des_iterative_core_round_stage #(.ENABLE_DECRYPT(ENABLE_DECRYPT)) u_stage (
            .l_in      (l_ch[g]),
            .r_in      (r_ch[g]),
            .c_in      (c_ch[g]),
            .d_in      (d_ch[g]),
            .round_idx (base_idx + 5'(g + 1)),
            .mode      (mode_q),
            .l_out     (l_ch[g+1]),
            .r_out     (r_ch[g+1]),
            .c_out     (c_ch[g+1]),
            .d_out     (d_ch[g+1])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (plaintext_valid_din)  state_nxt = ST_ROUND;
            ST_ROUND: if (last_step)            state_nxt = ST_DONE;
            ST_DONE:  if (ciphertext_ready_din) state_nxt = ST_IDLE;
            default:                            state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        plaintext_ready_dout  = (state == ST_IDLE);
        ciphertext_valid_dout = (state == ST_DONE);
        busy_dout             = (state == ST_ROUND) || (state == ST_DONE);
    end

    // Output skips the final swap: FP is applied to {R16, L16}.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l_q             <= '0;
            r_q             <= '0;
            c_q             <= '0;
            d_q             <= '0;
            round_cnt       <= '0;
            mode_q          <= 1'b0;
            ciphertext_dout <= '0;
        end else if (state == ST_IDLE) begin
            if (plaintext_valid_din) begin
                {l_q, r_q} <= ip_perm(plaintext_din);
                {c_q, d_q} <= pc1_perm(key_din);
                mode_q     <= decrypt_din & ENABLE_DECRYPT;
                round_cnt  <= '0;
            end
        end else if (state == ST_ROUND) begin
            l_q       <= l_ch[ROUNDS_PER_CYCLE];
            r_q       <= r_ch[ROUNDS_PER_CYCLE];
            c_q       <= c_ch[ROUNDS_PER_CYCLE];
            d_q       <= d_ch[ROUNDS_PER_CYCLE];
            round_cnt <= round_cnt + 1'b1;
            if (last_step) ciphertext_dout <= fp_perm({r_ch[ROUNDS_PER_CYCLE], l_ch[ROUNDS_PER_CYCLE]});
        end
    end

endmodule

// File: tb/tb_des_iterative_core.sv
// Directed bench for des_iterative_core across unroll factors and the decrypt-disabled build.
module tb_des_iterative_core;

    localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1  = 64'h85E813540F0AB405;
    localparam logic [63:0] K3  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] P3  = 64'h8787878787878787;
    localparam logic [63:0] C3  = 64'h0000000000000000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] pt = '0;
    logic [63:0] key = '0;
    logic        dec = 1'b0;
    logic [4:0]  pv = '0;
    logic [4:0]  cr = '0;
    logic [4:0]  pr;
    logic [4:0]  cv;
    logic [4:0]  busy;
    logic [63:0] ct [5];

    int unsigned n_pass = 0;
    int unsigned n_fail = 0;
    int unsigned n_total = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    des_iterative_core #(.ROUNDS_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset(reset), .plaintext_valid_din(pv[0]), .plaintext_ready_dout(pr[0]),
        .plaintext_din(pt), .key_din(key), .decrypt_din(dec), .ciphertext_valid_dout(cv[0]),
        .ciphertext_ready_din(cr[0]), .ciphertext_dout(ct[0]), .busy_dout(busy[0]));
    des_iterative_core #(.ROUNDS_PER_CYCLE(2)) dut2 (
        .clk(clk), .reset(reset), .plaintext_valid_din(pv[1]), .plaintext_ready_dout(pr[1]),
        .plaintext_din(pt), .key_din(key), .decrypt_din(dec), .ciphertext_valid_dout(cv[1]),
        .ciphertext_ready_din(cr[1]), .ciphertext_dout(ct[1]), .busy_dout(busy[1]));
    des_iterative_core #(.ROUNDS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .plaintext_valid_din(pv[2]), .plaintext_ready_dout(pr[2]),
        .plaintext_din(pt), .key_din(key), .decrypt_din(dec), .ciphertext_valid_dout(cv[2]),
        .ciphertext_ready_din(cr[2]), .ciphertext_dout(ct[2]), .busy_dout(busy[2]));
    des_iterative_core #(.ROUNDS_PER_CYCLE(16)) dut16 (
        .clk(clk), .reset(reset), .plaintext_valid_din(pv[3]), .plaintext_ready_dout(pr[3]),
        .plaintext_din(pt), .key_din(key), .decrypt_din(dec), .ciphertext_valid_dout(cv[3]),
        .ciphertext_ready_din(cr[3]), .ciphertext_dout(ct[3]), .busy_dout(busy[3]));
    des_iterative_core #(.ROUNDS_PER_CYCLE(1), .ENABLE_DECRYPT(1'b0)) dut_nodec (
        .clk(clk), .reset(reset), .plaintext_valid_din(pv[4]), .plaintext_ready_dout(pr[4]),
        .plaintext_din(pt), .key_din(key), .decrypt_din(dec), .ciphertext_valid_dout(cv[4]),
        .ciphertext_ready_din(cr[4]), .ciphertext_dout(ct[4]), .busy_dout(busy[4]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Submit one block, scramble inputs mid-flight, and check latency and result.
    task automatic run_block(input int unsigned d, input string tag, input logic [63:0] k,
                             input logic [63:0] p, input logic d_in, input logic [63:0] exp,
                             input int unsigned lat);
        int unsigned cyc;
        logic [63:0] want;
        cyc = 0;
        while (!pr[d] && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_rdy_before"}, 64'(pr[d]), 64'd1);
        @(negedge clk);
        key = k; pt = p; dec = d_in; pv[d] = 1'b1;
        @(posedge clk); #1;
        pv[d] = 1'b0;
        exp_q.push_back(exp);
        check({tag, "_busy"}, 64'(busy[d]), 64'd1);
        check({tag, "_rdy_low"}, 64'(pr[d]), 64'd0);
        key = {$urandom, $urandom};
        pt  = {$urandom, $urandom};
        dec = ~d_in;
        cyc = 0;
        while (!cv[d] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        want = exp_q.pop_front();
        check({tag, "_ct"}, ct[d], want);
    endtask

    task automatic finish_block(input int unsigned d, input string tag);
        @(negedge clk);
        cr[d] = 1'b1;
        @(posedge clk); #1;
        cr[d] = 1'b0;
        check({tag, "_valid_drop"}, 64'(cv[d]), 64'd0);
        check({tag, "_rdy_back"}, 64'(pr[d]), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit exceeded");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("reset_valid_%0d", i), 64'(cv[i]), 64'd0);
            check($sformatf("reset_ct_%0d", i), ct[i], 64'd0);
            check($sformatf("reset_ready_%0d", i), 64'(pr[i]), 64'd1);
            check($sformatf("reset_busy_%0d", i), 64'(busy[i]), 64'd0);
        end

        run_block(0, "enc1", K1, P1, 1'b0, C1, 16);
        finish_block(0, "enc1");
        run_block(0, "dec1", K1, C1, 1'b1, P1, 16);
        finish_block(0, "dec1");

        run_block(0, "enc3_rpc1", K3, P3, 1'b0, C3, 16);
        finish_block(0, "enc3_rpc1");
        run_block(1, "enc3_rpc2", K3, P3, 1'b0, C3, 8);
        finish_block(1, "enc3_rpc2");
        run_block(2, "enc3_rpc4", K3, P3, 1'b0, C3, 4);
        finish_block(2, "enc3_rpc4");
        run_block(3, "enc3_rpc16", K3, P3, 1'b0, C3, 1);
        finish_block(3, "enc3_rpc16");
        run_block(3, "dec1_rpc16", K1, C1, 1'b1, P1, 1);
        finish_block(3, "dec1_rpc16");

        // Backpressure, with a stray input valid that must be ignored while DONE.
        run_block(0, "bp", K1, P1, 1'b0, C1, 16);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                @(negedge clk);
                pt = P3; key = K3; pv[0] = 1'b1;
            end
            @(posedge clk); #1;
            check($sformatf("bp_valid_%0d", i), 64'(cv[0]), 64'd1);
            check($sformatf("bp_ct_%0d", i), ct[0], C1);
            check($sformatf("bp_rdy_%0d", i), 64'(pr[0]), 64'd0);
        end
        @(negedge clk);
        pv[0] = 1'b0;
        finish_block(0, "bp");

        // Abort mid-flight with reset during the 7th ROUND cycle.
        @(negedge clk);
        key = K3; pt = P3; dec = 1'b0; pv[0] = 1'b1;
        @(posedge clk); #1;
        pv[0] = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_valid_async", 64'(cv[0]), 64'd0);
        @(posedge clk); #1;
        check("abort_valid", 64'(cv[0]), 64'd0);
        check("abort_ct", ct[0], 64'd0);
        check("abort_ready", 64'(pr[0]), 64'd1);
        check("abort_busy", 64'(busy[0]), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_block(0, "after_abort", K1, P1, 1'b0, C1, 16);
        finish_block(0, "after_abort");

        run_block(4, "nodec_enc", K1, P1, 1'b1, C1, 16);
        finish_block(4, "nodec_enc");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
